serial_rx_deframer: RTL and testbench
=====================================

Name: serial_rx_deframer

Overview:
- 8-lane serial receiver for the output-stage link, in the loopback/verification path.
- Per lane, deserialises an MSB-first bitstream framed by a valid strobe into a left-aligned 128-bit word plus bit length.
- A round-robin arbiter merges completed frames from all lanes onto one valid/ready frame port.
- Serves as the bit-exact inverse of the output-stage transmitter.

Parameters:
- NUM_CH, 8, number of serial lanes (1..8).
- DATA_W, 128, frame payload register width.
- LEN_W, 16, width of the received bit-length counter.

Ports:
- clk_out16x  input  1  serial bit clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  NUM_CH  serial data bit per lane.
- data_vld  input  NUM_CH  per-lane frame strobe; high on every bit cycle of a frame.
- frame_valid  output  1  output frame available.
- frame_ready  input  1  consumer accepts frame when frame_valid&&frame_ready.
- frame_data  output  DATA_W  received bits, first bit at [DATA_W-1].
- frame_len  output  LEN_W  number of bit cycles in frame.
- frame_ch  output  3  source lane index.
- frame_trunc  output  1  frame_len > DATA_W; bits beyond DATA_W discarded.
- ovf  output  NUM_CH  one-cycle pulse per lane when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0; lane shift registers, counters, pending flags, RR pointer (lane 0) and output stage cleared. Reset mid-frame discards partial frames; after release a lane waits for a fresh data_vld rising edge. A lane whose data_vld is already high at release is not captured until data_vld drops.
- Lane FSM, states IDLE / RECV:
  - IDLE: on data_vld=1, load bit k=0 into data[DATA_W-1], len<=1, go RECV.
  - RECV: while data_vld=1, store bit k into data[DATA_W-1-k] if k<DATA_W, else drop it and set trunc. len increments, saturating at 2^LEN_W-1.
  - First cycle data_vld=0: frame complete; go IDLE. Unreceived low bits read 0.
  - Frames with data_vld continuously high form one frame; a 1-cycle gap separates frames.
- Lane holding buffer, one deep:
  - On completion with pending=0: copy data/len/trunc, set pending.
  - If pending=1 and not granted on the same edge: drop the new frame, pulse ovf[i]; the held frame is untouched.
  - If pending is granted on the same edge: the new frame is accepted, no drop.
- Arbiter/output register:
  - Output register loads when empty or when frame_valid&&frame_ready.
  - Grant goes to the first pending lane at or after the RR pointer; the pointer then moves to granted lane+1 (mod NUM_CH).
- Latency: completion sampled at edge E; pending after E; frame_valid after E+1 if the output is free.
- Output handshake: frame_valid holds and frame_* are stable until accepted. Throughput is 1 frame/cycle with frame_ready=1.
- frame_len=0 never occurs.

Optional Feature:
- Macro: RX_DROP_CNT_EN.
- Defined: extra port drop_cnt output 16 counts total ovf pulses across all lanes, saturating at 16'hFFFF. Several lanes dropping in the same cycle add their popcount; reset clears it to 0.
- Undefined: port and counter absent; ovf pulses are unchanged.

Decomposition:
- Shared package serial_link_pkg:
  - DATA_W, LEN_W, NUM_CH, CH_W=3.
  - frame struct typedef {data, len, ch, trunc}.
  - Lane state enum {IDLE, RECV}.
- Sub-module serial_rx_lane holds one lane FSM, counter and holding buffer, with a pending/grant interface. The top level instantiates NUM_CH lanes, the RR arbiter and the output register.

Test Plan:
- Lane 0 receives 0xA5 followed by 120 zero bits, data_vld high 128 cycles → one frame: data[127:120]=0xA5, rest 0, len=128, ch=0, trunc=0.
- Lane 3 sends 5 bits 1,0,1,1,0 → data[127:123]=5'b10110, data[122:0]=0, len=5, trunc=0.
- Lane 5 holds data_vld for 200 cycles → len=200, trunc=1, data equals the first 128 bits.
- All 8 lanes end 16-bit frames on the same cycle with frame_ready=1 → 8 consecutive frames, ch order 0..7. A second simultaneous burst yields the same order, the pointer having wrapped to 0.
- Lane 2 sends two frames with frame_ready=0 → frame 1 held on output, frame 2 pending. A third frame pulses ovf[2] once (drop_cnt=1 with RX_DROP_CNT_EN); after frame_ready=1, frames 1 and 2 are delivered intact.
- rst asserted mid-frame on lane 1 → all outputs 0 immediately. After release with data_vld still high, no frame until data_vld drops and rises again.

Source files
------------

// File: rtl/serial_rx_deframer_pkg.sv
// Shared types and sizing for the serial link receiver (package serial_link_pkg).
// Frame layout: left-aligned payload, bit count, source lane, truncation flag.
package serial_link_pkg;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 16;
  localparam int CH_W   = 3;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} lane_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic [CH_W-1:0]   ch;
    logic              trunc;
  } frame_t;
endpackage

// File: rtl/serial_rx_deframer_if.sv
// Merged output frame port (valid/ready) of the serial receiver.
interface serial_rx_deframer_if;
  import serial_link_pkg::*;
  logic              frame_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] frame_data;
  logic [LEN_W-1:0]  frame_len;
  logic [CH_W-1:0]   frame_ch;
  logic              frame_trunc;

  modport master (output frame_valid, frame_data, frame_len, frame_ch, frame_trunc,
                  input  frame_ready);
  modport slave  (input  frame_valid, frame_data, frame_len, frame_ch, frame_trunc,
                  output frame_ready);
endinterface

// File: rtl/serial_rx_deframer_lane.sv
// One receive lane: MSB-first deserialiser FSM, saturating bit counter and a
// one-deep holding buffer that the arbiter drains through pend/grant.
module serial_rx_lane
  import serial_link_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   data_in,
  input  logic   data_vld,
  input  logic   grant,
  output logic   pend,
  output frame_t hold,
  output logic   ovf
);
  localparam int IDX_W = $clog2(DATA_W);

  lane_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              trunc_q, trunc_d;
  logic              armed_q, armed_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  frame_t            hold_q, hold_d;
  logic              comp;
  logic [IDX_W-1:0]  bit_idx;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    trunc_d = trunc_q;
    comp    = 1'b0;
    // a strobe already high out of reset must drop before a frame can start
    armed_d = armed_q | ~data_vld;
    bit_idx = IDX_W'(DATA_W-1) - len_q[IDX_W-1:0];
    case (state_q)
      IDLE: if (data_vld && armed_q) begin
        data_d             = '0;
        data_d[DATA_W-1]   = data_in;
        len_d              = LEN_W'(1);
        trunc_d            = 1'b0;
        state_d            = RECV;
      end
      RECV: if (data_vld) begin
        if (len_q < LEN_W'(DATA_W)) data_d[bit_idx] = data_in;
        else                        trunc_d = 1'b1;
        if (len_q != '1) len_d = len_q + LEN_W'(1);
      end else begin
        comp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pend_d = pend_q & ~grant;
    hold_d = hold_q;
    ovf_d  = 1'b0;
    if (comp) begin
      // a grant on this edge frees the slot, so the new frame still fits
      if (!pend_q || grant) begin
        pend_d = 1'b1;
        hold_d = '{data: data_q, len: len_q, ch: CH_W'(LANE_ID), trunc: trunc_q};
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  assign pend = pend_q;
  assign hold = hold_q;
  assign ovf  = ovf_q;
endmodule

// File: rtl/serial_rx_deframer.sv
// 8-lane serial receive deframer: per-lane deserialisers merged by a round-robin
// arbiter into one registered frame port. RX_DROP_CNT_EN adds a saturating drop_cnt.
module serial_rx_deframer #(
  parameter int NUM_CH = serial_link_pkg::NUM_CH
) (
  input  logic                      clk_out16x,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         data_in,
  input  logic [NUM_CH-1:0]         data_vld,
  serial_rx_deframer_if.master      fo,
  output logic [NUM_CH-1:0]         ovf
`ifdef RX_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);
  import serial_link_pkg::*;

  logic [NUM_CH-1:0] pend, grant;
  frame_t            hold [NUM_CH];
  frame_t            out_q, out_d, sel;
  logic              out_vld_q, out_vld_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              load, found;
  int                idx, gidx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    serial_rx_lane #(.LANE_ID(i)) u_lane (
      .clk      (clk_out16x),
      .rst      (rst),
      .data_in  (data_in[i]),
      .data_vld (data_vld[i]),
      .grant    (grant[i]),
      .pend     (pend[i]),
      .hold     (hold[i]),
      .ovf      (ovf[i])
    );
  end

  always_comb begin
    found = 1'b0;
    idx   = 0;
    gidx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_q) + i) % NUM_CH;
      if (!found && pend[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    sel  = hold[gidx];
    load = !out_vld_q || fo.frame_ready;
    for (int i = 0; i < NUM_CH; i++) grant[i] = load && found && (gidx == i);

    out_d     = out_q;
    out_vld_d = out_vld_q;
    rr_d      = rr_q;
    if (load) begin
      out_vld_d = found;
      if (found) begin
        out_d = sel;
        rr_d  = (gidx == NUM_CH-1) ? '0 : CH_W'(gidx + 1);
      end
    end
  end

  always_ff @(posedge clk_out16x or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rr_q      <= '0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      rr_q      <= rr_d;
    end
  end

  assign fo.frame_valid = out_vld_q;
  assign fo.frame_data  = out_q.data;
  assign fo.frame_len   = out_q.len;
  assign fo.frame_ch    = out_q.ch;
  assign fo.frame_trunc = out_q.trunc;

`ifdef RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + 17'(ovf[i]);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_out16x or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer: framing, truncation, RR order,
// overflow/drop and mid-frame reset, all against hand-derived expectations.
module tb_serial_rx_deframer;
  import serial_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in, data_vld, ovf;
`ifdef RX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif
  serial_rx_deframer_if fo();

  serial_rx_deframer u_dut (
    .clk_out16x (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_vld   (data_vld),
    .fo         (fo),
    .ovf        (ovf)
`ifdef RX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     ovf_cnt [8];
  frame_t q [$];
  int     qcyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // frames are taken at the negedge preceding the accepting posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (fo.frame_valid && fo.frame_ready) begin
        q.push_back('{data: fo.frame_data, len: fo.frame_len, ch: fo.frame_ch,
                      trunc: fo.frame_trunc});
        qcyc.push_back(cyc);
      end
      for (int i = 0; i < 8; i++) ovf_cnt[i] += int'(ovf[i]);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int lane, input logic [127:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      data_in[lane]  = (k < 128) ? pat[127-k] : k[0];
      data_vld[lane] = 1'b1;
      tick();
    end
    data_vld[lane] = 1'b0;
    data_in[lane]  = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_count"}, 128'(q.size() >= n), 128'(1));
  endtask

  task automatic pop_chk(input string tag, input logic [127:0] d, input int len,
                         input int ch, input logic trunc);
    frame_t f;
    if (q.size() == 0) begin
      chk({tag, "_present"}, 128'(0), 128'(1));
    end else begin
      f = q.pop_front();
      void'(qcyc.pop_front());
      chk({tag, "_data"}, f.data, d);
      chk({tag, "_len"}, 128'(f.len), 128'(len));
      chk({tag, "_ch"}, 128'(f.ch), 128'(ch));
      chk({tag, "_trunc"}, 128'(f.trunc), 128'(trunc));
    end
  endtask

  logic [15:0]  bp [8];
  logic [15:0]  w;
  logic [127:0] pat;
  int           c0;

  initial begin
    bp = '{16'h8001, 16'h1234, 16'hFFFF, 16'h0F0F, 16'hA5A5, 16'h0001, 16'h8000, 16'hC3C3};
    for (int i = 0; i < 8; i++) ovf_cnt[i] = 0;
    rst = 1'b1; data_in = '0; data_vld = '0; fo.frame_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 128'(fo.frame_valid), 128'(0));
    chk("rst_data", fo.frame_data, 128'(0));
    chk("rst_len", 128'(fo.frame_len), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
`ifdef RX_DROP_CNT_EN
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
    rst = 1'b0;
    tick(); tick();

    // two simultaneous 16-bit bursts on all lanes
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 16; k++) begin
        for (int l = 0; l < 8; l++) begin
          w = (b == 0) ? bp[l] : ~bp[l];
          data_in[l] = w[15-k];
        end
        data_vld = '1;
        tick();
      end
      data_vld = '0; data_in = '0;
      tick();
      wait_frames("burst", 8, 40);
      if (qcyc.size() >= 8) chk("burst_b2b", 128'(qcyc[7] - qcyc[0]), 128'(7));
      for (int l = 0; l < 8; l++) begin
        w = (b == 0) ? bp[l] : ~bp[l];
        pop_chk("burst", {w, 112'b0}, 16, l, 1'b0);
      end
    end

    send(0, {8'hA5, 120'b0}, 128);
    wait_frames("l0", 1, 20);
    pop_chk("l0", {8'hA5, 120'b0}, 128, 0, 1'b0);

    send(3, {5'b10110, 123'b0}, 5);
    chk("l3_lat_e", 128'(fo.frame_valid), 128'(0));
    tick();
    chk("l3_lat_e1", 128'(fo.frame_valid), 128'(1));
    wait_frames("l3", 1, 20);
    pop_chk("l3", {5'b10110, 123'b0}, 5, 3, 1'b0);

    pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
    send(5, pat, 200);
    wait_frames("l5", 1, 20);
    pop_chk("l5", pat, 200, 5, 1'b1);

    // overflow: output full and lane 2 pending, third frame dropped
    fo.frame_ready = 1'b0;
    send(2, {8'h3C, 120'b0}, 8);
    send(2, {12'hABC, 116'b0}, 12);
    send(2, {4'hF, 124'b0}, 4);
    tick(); tick();
    chk("l2_ovf_cnt", 128'(ovf_cnt[2]), 128'(1));
    chk("l2_held_valid", 128'(fo.frame_valid), 128'(1));
`ifdef RX_DROP_CNT_EN
    chk("l2_drop_cnt", 128'(drop_cnt), 128'(1));
`endif
    fo.frame_ready = 1'b1;
    wait_frames("l2", 2, 20);
    pop_chk("l2_f1", {8'h3C, 120'b0}, 8, 2, 1'b0);
    pop_chk("l2_f2", {12'hABC, 116'b0}, 12, 2, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("l2_no_extra", 128'(q.size()), 128'(0));

    // mid-frame reset with a frame held on the output
    fo.frame_ready = 1'b0;
    send(4, {8'hFF, 120'b0}, 8);
    tick();
    chk("pre_rst_valid", 128'(fo.frame_valid), 128'(1));
    data_vld[1] = 1'b1; data_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(fo.frame_valid), 128'(0));
    chk("mid_rst_data", fo.frame_data, 128'(0));
    chk("mid_rst_len", 128'(fo.frame_len), 128'(0));
    chk("mid_rst_ch", 128'(fo.frame_ch), 128'(0));
    tick(); tick();
    q.delete(); qcyc.delete();
    rst = 1'b0; fo.frame_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_hold_q", 128'(q.size()), 128'(0));
    chk("post_rst_hold_v", 128'(fo.frame_valid), 128'(0));
    data_vld[1] = 1'b0; data_in[1] = 1'b0;
    c0 = 0;
    for (int i = 0; i < 3; i++) begin tick(); c0 += int'(fo.frame_valid); end
    chk("post_rst_drop_v", 128'(c0), 128'(0));
    send(1, {3'b101, 125'b0}, 3);
    wait_frames("l1", 1, 20);
    pop_chk("l1", {3'b101, 125'b0}, 3, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
